// File: rtl/gray_pkg.sv
// Shared constants and types for the Gray code counter.
package gray_pkg;

  localparam int unsigned GRAY_BW_DEFAULT = 8;
  localparam int unsigned GRAY_BW_MAX     = 32;

  // Bound constants at maximum width; users slice down to their own width.
  localparam logic [GRAY_BW_MAX-1:0] GRAY_ALL_ONES = '1;
  localparam logic [GRAY_BW_MAX-1:0] GRAY_ZERO     = '0;

  // Kind of update taken on an edge, after priority resolution.
  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_LOAD = 2'd1,
    STEP_UP   = 2'd2,
    STEP_DOWN = 2'd3
  } step_e;

endpackage

// File: rtl/gray_code_counter_if.sv
// Control and result signals of the Gray code counter.
interface gray_code_counter_if
  import gray_pkg::*;
#(
  parameter int unsigned BW_DATA = GRAY_BW_DEFAULT
);

  logic               i_en;
  logic               i_up;
  logic               i_load;
  logic [BW_DATA-1:0] i_load_binary;
  logic [BW_DATA-1:0] o_binary;
  logic [BW_DATA-1:0] o_gray;
  logic               o_tc;

  // Counter side.
  modport slave (
    input  i_en, i_up, i_load, i_load_binary,
    output o_binary, o_gray, o_tc
  );

  // Controller side.
  modport master (
    output i_en, i_up, i_load, i_load_binary,
    input  o_binary, o_gray, o_tc
  );

endinterface

// File: rtl/gray_code_enc.sv
// Combinational binary to reflected Gray code encoder.
module gray_code_enc #(
  parameter int unsigned BW_DATA = 8
) (
  input  logic [BW_DATA-1:0] i_binary,
  output logic [BW_DATA-1:0] o_gray
);

  assign o_gray = i_binary ^ (i_binary >> 1);

endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter with registered Gray code and terminal-count outputs.
// Optional macro GRAY_CNT_SAT_EN: saturate at the bound instead of wrapping.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int unsigned        BW_DATA  = GRAY_BW_DEFAULT,
  parameter logic [BW_DATA-1:0] INIT_VAL = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  gray_code_counter_if.slave bus
);

  localparam logic [BW_DATA-1:0] L_ONES      = GRAY_ALL_ONES[BW_DATA-1:0];
  localparam logic [BW_DATA-1:0] L_ZERO      = GRAY_ZERO[BW_DATA-1:0];
  localparam logic [BW_DATA-1:0] L_INIT_GRAY = INIT_VAL ^ (INIT_VAL >> 1);

  logic [BW_DATA-1:0] r_binary;
  logic [BW_DATA-1:0] r_gray;
  logic               r_tc;

  step_e              w_step;
  logic               w_at_bound;
  logic [BW_DATA-1:0] w_next_bin;
  logic [BW_DATA-1:0] w_next_gray;
  logic               w_next_tc;

  // Resolve load/enable priority and form the next binary count.
  always_comb begin
    w_step     = STEP_HOLD;
    w_at_bound = 1'b0;
    w_next_bin = r_binary;
    w_next_tc  = 1'b0;

    if (bus.i_load) begin
      w_step = STEP_LOAD;
    end else if (bus.i_en) begin
      w_step = bus.i_up ? STEP_UP : STEP_DOWN;
    end

    case (w_step)
      STEP_LOAD: w_next_bin = bus.i_load_binary;
      STEP_UP: begin
        w_at_bound = (r_binary == L_ONES);
        w_next_bin = r_binary + BW_DATA'(1);
      end
      STEP_DOWN: begin
        w_at_bound = (r_binary == L_ZERO);
        w_next_bin = r_binary - BW_DATA'(1);
      end
      STEP_HOLD: w_next_bin = r_binary;
      default:   w_next_bin = r_binary;
    endcase

`ifdef GRAY_CNT_SAT_EN
    // Saturate: a step from the bound in the bound direction holds the count.
    if (w_at_bound) begin
      w_next_bin = r_binary;
    end
`endif

    w_next_tc = w_at_bound;
  end

  // Gray code derived from the next-state value so both outputs update together.
  gray_code_enc #(
    .BW_DATA (BW_DATA)
  ) u_gray_enc (
    .i_binary (w_next_bin),
    .o_gray   (w_next_gray)
  );

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_binary <= INIT_VAL;
      r_gray   <= L_INIT_GRAY;
      r_tc     <= 1'b0;
    end else begin
      r_binary <= w_next_bin;
      r_gray   <= w_next_gray;
      r_tc     <= w_next_tc;
    end
  end

  assign bus.o_binary = r_binary;
  assign bus.o_gray   = r_gray;
  assign bus.o_tc     = r_tc;

endmodule
